mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-host to one-agent Avalon-MM arbiter.
- Lets the CPU instruction manager (read-only) and data manager (read/write) share one single-ported memory/peripheral agent.
- Sits between Cpu and the memory in Computer, replacing the dual-ported memory arrangement.
- Round-robin fair grant, registered grant, one transfer per grant; Avalon waitrequest semantics on every port.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; byteenable width is DATA_W/8
- PRIORITY_D, 1, port preferred on the first arbitration after reset or idle with no history (1 = data, 0 = instruction)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_address  in  ADDR_W  instruction host address
- i_read  in  1  instruction host read request
- i_agent_to_host  out  DATA_W  instruction read data
- i_waitrequest  out  1  instruction host stall
- d_address  in  ADDR_W  data host address
- d_read  in  1  data host read request
- d_write  in  1  data host write request
- d_byteenable  in  DATA_W/8  data host byte lanes
- d_host_to_agent  in  DATA_W  data host write data
- d_agent_to_host  out  DATA_W  data host read data
- d_waitrequest  out  1  data host stall
- m_address  out  ADDR_W  agent address
- m_read  out  1  agent read strobe
- m_write  out  1  agent write strobe
- m_byteenable  out  DATA_W/8  agent byte lanes
- m_host_to_agent  out  DATA_W  agent write data
- m_agent_to_host  in  DATA_W  agent read data
- m_waitrequest  in  1  agent stall

Behaviour:
- FSM states: IDLE, GRANT_I, GRANT_D. A last_grant register (0 = I, 1 = D) drives round-robin.
- Request terms: req_i = i_read; req_d = d_read | d_write.
- In IDLE, all m_ strobes are 0 and m_address/m_byteenable/m_host_to_agent are 0. Both host waitrequests are 1.
- Arbitration happens in IDLE and on the completion cycle of a grant:
  - Only one request pending: grant that port.
  - Both pending: grant the port not equal to last_grant.
  - From IDLE with no history since reset: use PRIORITY_D.
  - The grant is registered, so the agent sees the request the cycle after it is first sampled.
- GRANT_I:
  - m_address = i_address, m_read = i_read, m_write = 0, m_byteenable = all ones, m_host_to_agent = 0.
  - i_waitrequest = m_waitrequest; i_agent_to_host = m_agent_to_host.
  - d_waitrequest = 1.
- GRANT_D:
  - m_ signals mirror the d_ signals.
  - d_waitrequest = m_waitrequest; d_agent_to_host = m_agent_to_host.
  - i_waitrequest = 1.
- Completion is granted state with m_waitrequest = 0. On completion:
  - last_grant is set to the current port.
  - Next state is the other port if it is requesting, otherwise IDLE.
  - The completing host's request in that cycle is treated as consumed.
- Ungranted hosts hold their request stable while waitrequest = 1 (Avalon rule). The arbiter never drops a pending request.
- Latency: minimum 2 cycles per transfer from request to completion (1 arbitration + 1 agent cycle with zero-wait agent). Alternating requesters sustain 1 transfer/cycle after the first.
- A grant stays held for the whole transfer regardless of m_waitrequest duration; there is no preemption.
- Granted host drops its request before completion (protocol violation): return to IDLE next cycle. Simulation assertion fires.
- d_read & d_write both 1: forwarded unchanged. Simulation assertion fires.
- Reset mid-transfer: next cycle is IDLE, last_grant = PRIORITY_D history cleared, all m_ strobes 0, both host waitrequests 1. Any agent transfer in flight is abandoned.
- i_agent_to_host and d_agent_to_host always carry m_agent_to_host; they are valid only on that host's completion cycle.

Optional Feature:
- Macro: ARB_STATS_EN
- When defined, adds outputs:
  - stat_grants_i (32)
  - stat_grants_d (32)
  - stat_contention (32): cycles where both req_i and req_d are 1 and at least one is waiting
  - stat_agent_stall (32): granted cycles with m_waitrequest = 1
- Counters clear on rst, saturate at all ones, and increment on completion/cycle as named.
- When not defined, the ports and logic are absent; functional behaviour is identical.

Test Plan:
- Reset, then i_read at 0x100 only, zero-wait agent returning 0xDEADBEEF → m_read high 1 cycle after request; i_waitrequest low that cycle; i_agent_to_host = 0xDEADBEEF; d_waitrequest stays 1.
- Both hosts request at the same cycle after reset (d_write 0x200 data 0x12345678 be 0xF, i_read 0x104) → D granted first (PRIORITY_D = 1), I granted the next cycle; m_write then m_read on consecutive cycles.
- Both request continuously for 8 transfers → grants alternate D, I, D, I…; each host gets 4 completions; neither waits more than 1 transfer.
- Agent holds m_waitrequest = 1 for 3 cycles during GRANT_D while i_read is pending → grant held; i_waitrequest = 1 throughout; I granted right after D completes.
- Assert rst during GRANT_I stall → next cycle IDLE; m_read = 0; both waitrequests = 1; after release a lone i_read is granted normally.
- With ARB_STATS_EN, run the alternation test → stat_grants_i = 4, stat_grants_d = 4, stat_contention nonzero, stat_agent_stall = 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-host to one-agent Avalon-MM arbiter: round-robin, registered grant, one transfer per grant.
// Optional counters are built when ARB_STATS_EN is defined.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit PRIORITY_D = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef ARB_STATS_EN
  output logic [31:0]         stat_grants_i,
  output logic [31:0]         stat_grants_d,
  output logic [31:0]         stat_contention,
  output logic [31:0]         stat_agent_stall,
`endif
  output logic [1:0]          dbg_state,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic [DATA_W-1:0]   i_agent_to_host,
  output logic                i_waitrequest,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_host_to_agent,
  output logic [DATA_W-1:0]   d_agent_to_host,
  output logic                d_waitrequest,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_host_to_agent,
  input  logic [DATA_W-1:0]   m_agent_to_host,
  input  logic                m_waitrequest
);

  // Handshake: a transfer completes on a cycle where the host request is high
  // and its waitrequest is low; while waitrequest is high the host holds its request.

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_grant;
  logic       have_history;
  logic       req_i;
  logic       req_d;
  logic       pick_d;
  logic       done_i;
  logic       done_d;

  assign req_i     = i_read;
  assign req_d     = d_read | d_write;
  assign done_i    = (state == GRANT_I) && req_i && !m_waitrequest;
  assign done_d    = (state == GRANT_D) && req_d && !m_waitrequest;
  assign dbg_state = state;

  // Until the first completion after reset there is no history to rotate from.
  always_comb begin
    pick_d = req_d;
    if (req_i && req_d) begin
      pick_d = have_history ? ~last_grant : PRIORITY_D;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (req_i || req_d) state_nxt = pick_d ? GRANT_D : GRANT_I;
      end
      GRANT_I: begin
        if (!req_i)              state_nxt = IDLE;
        else if (m_waitrequest)  state_nxt = GRANT_I;
        else                     state_nxt = req_d ? GRANT_D : IDLE;
      end
      GRANT_D: begin
        if (!req_d)              state_nxt = IDLE;
        else if (m_waitrequest)  state_nxt = GRANT_D;
        else                     state_nxt = req_i ? GRANT_I : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= PRIORITY_D;
      have_history <= 1'b0;
    end else begin
      state <= state_nxt;
      if (done_i || done_d) begin
        last_grant   <= done_d;
        have_history <= 1'b1;
      end
    end
  end

  assign i_agent_to_host = m_agent_to_host;
  assign d_agent_to_host = m_agent_to_host;

  always_comb begin
    m_address       = '0;
    m_read          = 1'b0;
    m_write         = 1'b0;
    m_byteenable    = '0;
    m_host_to_agent = '0;
    i_waitrequest   = 1'b1;
    d_waitrequest   = 1'b1;
    case (state)
      GRANT_I: begin
        m_address     = i_address;
        m_read        = i_read;
        m_byteenable  = '1;
        i_waitrequest = m_waitrequest;
      end
      GRANT_D: begin
        m_address       = d_address;
        m_read          = d_read;
        m_write         = d_write;
        m_byteenable    = d_byteenable;
        m_host_to_agent = d_host_to_agent;
        d_waitrequest   = m_waitrequest;
      end
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants_i    <= '0;
      stat_grants_d    <= '0;
      stat_contention  <= '0;
      stat_agent_stall <= '0;
    end else begin
      if (done_i && (stat_grants_i != '1)) stat_grants_i <= stat_grants_i + 32'd1;
      if (done_d && (stat_grants_d != '1)) stat_grants_d <= stat_grants_d + 32'd1;
      if (req_i && req_d && (i_waitrequest || d_waitrequest) && (stat_contention != '1))
        stat_contention <= stat_contention + 32'd1;
      if ((state != IDLE) && m_waitrequest && (stat_agent_stall != '1))
        stat_agent_stall <= stat_agent_stall + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_i_held: assert property (@(posedge clk) disable iff (rst) (state == GRANT_I) |-> i_read);
  a_d_held: assert property (@(posedge clk) disable iff (rst) (state == GRANT_D) |-> req_d);
  a_d_rw:   assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed protocol steps plus a randomized phase
// checked against a host-side memory model and a fairness bound.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] i_address;
  logic        i_read;
  logic [31:0] i_agent_to_host;
  logic        i_waitrequest;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byteenable;
  logic [31:0] d_host_to_agent;
  logic [31:0] d_agent_to_host;
  logic        d_waitrequest;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_host_to_agent;
  logic [31:0] m_agent_to_host;
  logic        m_waitrequest;
  logic [1:0]  dbg_state;
`ifdef ARB_STATS_EN
  logic [31:0] stat_grants_i;
  logic [31:0] stat_grants_d;
  logic [31:0] stat_contention;
  logic [31:0] stat_agent_stall;
`endif

  mem_bus_arbiter dut (
    .clk             (clk),
    .rst             (rst),
`ifdef ARB_STATS_EN
    .stat_grants_i   (stat_grants_i),
    .stat_grants_d   (stat_grants_d),
    .stat_contention (stat_contention),
    .stat_agent_stall(stat_agent_stall),
`endif
    .dbg_state       (dbg_state),
    .i_address       (i_address),
    .i_read          (i_read),
    .i_agent_to_host (i_agent_to_host),
    .i_waitrequest   (i_waitrequest),
    .d_address       (d_address),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_byteenable    (d_byteenable),
    .d_host_to_agent (d_host_to_agent),
    .d_agent_to_host (d_agent_to_host),
    .d_waitrequest   (d_waitrequest),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_byteenable    (m_byteenable),
    .m_host_to_agent (m_host_to_agent),
    .m_agent_to_host (m_agent_to_host),
    .m_waitrequest   (m_waitrequest)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- agent memory (environment) ----------------
  function automatic logic [31:0] init_word(input logic [5:0] idx);
    if (idx == 6'd0) return 32'hDEADBEEF;
    return {8'hA5, 2'b00, idx, 2'b11, ~idx, 8'h3C};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = data[8*b +: 8];
    return w;
  endfunction

  logic [31:0] agent_mem [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) agent_mem[k] <= init_word(k[5:0]);
    end else if (m_write && !m_waitrequest) begin
      agent_mem[m_address[7:2]] <= merge(agent_mem[m_address[7:2]], m_host_to_agent, m_byteenable);
    end
  end
  assign m_agent_to_host = agent_mem[m_address[7:2]];

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] ref_mem [64];
  logic [0:0]  exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_byteenable = '0; d_host_to_agent = '0;
  endtask

  // Returns at the drive point (#1 after a rising edge) of the first post-reset cycle.
  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    m_waitrequest = 1'b0;
    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k[5:0]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Randomized host/agent state
  bit          i_busy, d_busy, d_is_write;
  logic [31:0] i_addr_r, d_addr_r, d_wdata_r;
  logic [3:0]  d_be_r;
  int          i_other, d_other;

  task automatic rand_cycle(input bit allow_new);
    next_cycle();
    if (!i_busy && allow_new && ($urandom_range(0, 2) == 0)) begin
      i_busy = 1'b1; i_other = 0;
      i_addr_r = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    end
    if (!d_busy && allow_new && ($urandom_range(0, 2) == 0)) begin
      d_busy = 1'b1; d_other = 0;
      d_is_write = 1'($urandom_range(0, 1));
      d_addr_r   = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      d_wdata_r  = $urandom;
      d_be_r     = 4'($urandom_range(0, 15));
    end
    i_read = i_busy; i_address = i_addr_r;
    d_read = d_busy && !d_is_write; d_write = d_busy && d_is_write;
    d_address = d_addr_r; d_host_to_agent = d_wdata_r; d_byteenable = d_be_r;
    m_waitrequest = ($urandom_range(0, 3) == 0);
    #1;
    chk("one_host_served", {63'd0, (!i_waitrequest && !d_waitrequest)}, 64'd0);
    if (i_read && !i_waitrequest) begin
      chk("rand_i_data", i_agent_to_host, ref_mem[i_addr_r[7:2]]);
      chk("fair_i", {63'd0, (i_other <= 1)}, 64'd1);
      i_busy = 1'b0;
      if (d_busy) d_other++;
    end else if ((d_read || d_write) && !d_waitrequest) begin
      if (d_is_write) ref_mem[d_addr_r[7:2]] = merge(ref_mem[d_addr_r[7:2]], d_wdata_r, d_be_r);
      else chk("rand_d_data", d_agent_to_host, ref_mem[d_addr_r[7:2]]);
      chk("fair_d", {63'd0, (d_other <= 1)}, 64'd1);
      d_busy = 1'b0;
      if (i_busy) i_other++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int got, ni, nd;
    rst = 1'b1;
    idle_inputs();
    m_waitrequest = 1'b0;

    // Reset state
    reset_dut();
    #1;
    chk("rst_i_wait", i_waitrequest, 1);
    chk("rst_d_wait", d_waitrequest, 1);
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_addr", m_address, 0);
    chk("rst_state_idle", dbg_state, 0);

    // Lone instruction read
    next_cycle();
    i_read = 1'b1; i_address = 32'h100; #1;
    chk("t1_arb_m_read", m_read, 0);
    chk("t1_arb_i_wait", i_waitrequest, 1);
    next_cycle(); #1;
    chk("t1_m_read", m_read, 1);
    chk("t1_m_addr", m_address, 32'h100);
    chk("t1_m_be", m_byteenable, 4'hF);
    chk("t1_i_wait", i_waitrequest, 0);
    chk("t1_i_data", i_agent_to_host, 32'hDEADBEEF);
    chk("t1_d_wait", d_waitrequest, 1);
    next_cycle();
    i_read = 1'b0; #1;
    chk("t1_done_m_read", m_read, 0);

    // Simultaneous requests after reset: data first, then instruction
    reset_dut();
    d_write = 1'b1; d_address = 32'h200; d_host_to_agent = 32'h12345678; d_byteenable = 4'hF;
    i_read = 1'b1; i_address = 32'h104; #1;
    chk("t2_arb_i_wait", i_waitrequest, 1);
    chk("t2_arb_d_wait", d_waitrequest, 1);
    next_cycle(); #1;
    chk("t2_m_write", m_write, 1);
    chk("t2_m_addr_d", m_address, 32'h200);
    chk("t2_m_wdata", m_host_to_agent, 32'h12345678);
    chk("t2_d_wait", d_waitrequest, 0);
    chk("t2_i_wait_held", i_waitrequest, 1);
    next_cycle();
    d_write = 1'b0; #1;
    chk("t2_m_read", m_read, 1);
    chk("t2_m_write_off", m_write, 0);
    chk("t2_m_addr_i", m_address, 32'h104);
    chk("t2_i_wait", i_waitrequest, 0);
    chk("t2_i_data", i_agent_to_host, ref_mem[1]);
    next_cycle();
    i_read = 1'b0; #1;
    chk("t2_done_m_read", m_read, 0);

    // Continuous contention: 8 transfers alternate D, I, D, I ...
    reset_dut();
    for (int k = 0; k < 8; k++) exp_q.push_back(1'((k % 2) == 0));
    got = 0; ni = 0; nd = 0;
    i_read = 1'b1; i_address = 32'h44;
    d_read = 1'b1; d_address = 32'h88;
    for (int c = 0; c < 24 && got < 8; c++) begin
      #1;
      if (!d_waitrequest || !i_waitrequest) begin
        chk("alt_order", {63'd0, !d_waitrequest}, {63'd0, exp_q.pop_front()});
        if (!d_waitrequest) nd++; else ni++;
        got++;
      end
      next_cycle();
      d_read = (nd < 4);
      i_read = (ni < 4);
    end
    chk("alt_total", got, 8);
    chk("alt_i_count", ni, 4);
    chk("alt_d_count", nd, 4);
    idle_inputs();
    next_cycle(); #1;
`ifdef ARB_STATS_EN
    chk("stat_grants_i", stat_grants_i, 4);
    chk("stat_grants_d", stat_grants_d, 4);
    chk("stat_contention_nz", {63'd0, (stat_contention != 0)}, 1);
    chk("stat_agent_stall", stat_agent_stall, 0);
`endif

    // Agent stalls during a data grant while an instruction read waits
    reset_dut();
    d_write = 1'b1; d_address = 32'h20; d_host_to_agent = 32'hCAFEF00D; d_byteenable = 4'h3;
    m_waitrequest = 1'b1;
    next_cycle();
    i_read = 1'b1; i_address = 32'h30; #1;
    chk("t4_m_write", m_write, 1);
    chk("t4_d_wait_stall", d_waitrequest, 1);
    chk("t4_i_wait_b", i_waitrequest, 1);
    for (int c = 0; c < 2; c++) begin
      next_cycle(); #1;
      chk("t4_grant_held", m_write, 1);
      chk("t4_i_wait_cd", i_waitrequest, 1);
    end
    next_cycle();
    m_waitrequest = 1'b0; #1;
    chk("t4_d_done", d_waitrequest, 0);
    chk("t4_i_wait_e", i_waitrequest, 1);
    next_cycle();
    d_write = 1'b0; #1;
    chk("t4_i_granted", m_read, 1);
    chk("t4_i_addr", m_address, 32'h30);
    chk("t4_i_wait_f", i_waitrequest, 0);
    chk("t4_i_data", i_agent_to_host, ref_mem[12]);
    next_cycle();
    i_read = 1'b0; #1;
    chk("t4_done", m_read, 0);
`ifdef ARB_STATS_EN
    chk("t4_stat_stall", stat_agent_stall, 3);
`endif

    // Reset during an instruction grant stall
    reset_dut();
    i_read = 1'b1; i_address = 32'h40; m_waitrequest = 1'b1;
    next_cycle(); #1;
    chk("t5_m_read_stall", m_read, 1);
    chk("t5_i_wait_stall", i_waitrequest, 1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; #1;
    chk("t5_rst_m_read", m_read, 0);
    chk("t5_rst_i_wait", i_waitrequest, 1);
    chk("t5_rst_d_wait", d_waitrequest, 1);
    next_cycle();
    m_waitrequest = 1'b0; #1;
    chk("t5_regrant_m_read", m_read, 1);
    chk("t5_regrant_i_wait", i_waitrequest, 0);
    chk("t5_regrant_data", i_agent_to_host, ref_mem[16]);
    next_cycle();
    i_read = 1'b0; #1;
    chk("t5_done", m_read, 0);

    // Randomized traffic against the host-side memory model
    reset_dut();
    i_busy = 1'b0; d_busy = 1'b0; d_is_write = 1'b0;
    i_addr_r = '0; d_addr_r = '0; d_wdata_r = '0; d_be_r = '0;
    i_other = 0; d_other = 0;
    for (int c = 0; c < 600; c++) rand_cycle(1'b1);
    for (int c = 0; c < 60 && (i_busy || d_busy); c++) rand_cycle(1'b0);
    chk("drain_idle", {62'd0, i_busy, d_busy}, 0);
    next_cycle();
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
